// File: rtl/execute_mc.sv
// execute_mc: execute stage with single-cycle ALU/branch/HI-LO ops and an iterative
// shift-add multiplier writing HI/LO. Define EXECUTE_MC_DIV_EN to build the restoring divider.
module execute_mc #(
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                em_i_clk,
    input  logic                em_i_rst,
    input  logic                em_i_valid,
    output logic                em_o_ready,
    input  logic [3:0]          em_i_op,
    input  logic [DWIDTH-1:0]   em_i_data_rs,
    input  logic [DWIDTH-1:0]   em_i_data_rt,
    input  logic [15:0]         em_i_imm,
    input  logic                em_i_alu_src,
    input  logic [PC_WIDTH-1:0] em_i_pc,
    input  logic                em_i_flush,
    output logic                em_o_valid,
    output logic [DWIDTH-1:0]   em_o_alu_value,
    output logic                em_o_zero,
    output logic                em_o_change_pc,
    output logic [PC_WIDTH-1:0] em_o_alu_pc
);

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_MULT,
        OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_BEQ, OP_BNE, OP_NOP
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    localparam int            CW        = $clog2(DWIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DWIDTH - 1);

    state_e              r_state, w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [DWIDTH-1:0]   r_hi, r_lo;

    op_e                 w_op;
    logic                w_accept, w_start_mul, w_start_div, w_busy, w_last;
    logic                w_signed_op, w_rs_neg, w_rt_neg, w_taken;
    logic signed [15:0]  w_imm_s;
    logic [DWIDTH-1:0]   w_imm_ext, w_opb, w_diff, w_res, w_rs_mag, w_rt_mag;
    logic [PC_WIDTH-1:0] w_br_off;

    logic [2*DWIDTH-1:0] r_mcand, r_acc, w_acc_next, w_prod;
    logic [DWIDTH-1:0]   r_mplier;
    logic                r_mneg, w_mul_done;

    logic                w_div_done;
    logic [DWIDTH-1:0]   w_div_lo, w_div_hi;

    assign w_op        = op_e'(em_i_op);
    assign w_busy      = (r_state == S_MUL) || (r_state == S_DIV);
    assign em_o_ready  = !em_i_rst && ((r_state == S_IDLE) || (r_state == S_DONE));
    // Flush outranks the handshake: a flushed cycle accepts nothing.
    assign w_accept    = em_i_valid && em_o_ready && !em_i_flush;
    assign w_start_mul = w_accept && ((w_op == OP_MULT) || (w_op == OP_MULTU));
    assign w_last      = (r_cnt == LAST_ITER);

    assign w_imm_s   = em_i_imm;
    assign w_imm_ext = DWIDTH'(w_imm_s);
    assign w_br_off  = PC_WIDTH'(w_imm_s) << 2;
    assign w_opb     = em_i_alu_src ? w_imm_ext : em_i_data_rt;
    assign w_diff    = em_i_data_rs - em_i_data_rt;

    assign w_signed_op = (w_op == OP_MULT) || (w_op == OP_DIV);
    assign w_rs_neg    = w_signed_op && em_i_data_rs[DWIDTH-1];
    assign w_rt_neg    = w_signed_op && em_i_data_rt[DWIDTH-1];
    assign w_rs_mag    = w_rs_neg ? -em_i_data_rs : em_i_data_rs;
    assign w_rt_mag    = w_rt_neg ? -em_i_data_rt : em_i_data_rt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_res   = '0;
        w_taken = 1'b0;
        case (w_op)
            OP_ADD:  w_res = em_i_data_rs + w_opb;
            OP_SUB:  w_res = em_i_data_rs - w_opb;
            OP_AND:  w_res = em_i_data_rs & w_opb;
            OP_OR:   w_res = em_i_data_rs | w_opb;
            OP_XOR:  w_res = em_i_data_rs ^ w_opb;
            OP_SLT:  w_res = DWIDTH'($signed(em_i_data_rs) < $signed(w_opb));
            OP_SLTU: w_res = DWIDTH'(em_i_data_rs < w_opb);
            OP_MFHI: w_res = r_hi;
            OP_MFLO: w_res = r_lo;
            OP_BEQ: begin
                w_res   = w_diff;
                w_taken = (w_diff == '0);
            end
            OP_BNE: begin
                w_res   = w_diff;
                w_taken = (w_diff != '0);
            end
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_mul)      w_state_next = S_MUL;
                else if (w_start_div) w_state_next = S_DIV;
                else                  w_state_next = S_IDLE;
            end
            S_MUL, S_DIV: begin
                if (em_i_flush)  w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge em_i_clk or posedge em_i_rst) begin
        if (em_i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_busy && !w_last && !em_i_flush) ? r_cnt + 1'b1 : '0;
        end
    end

    assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;
    assign w_prod     = r_mneg ? -w_acc_next : w_acc_next;
    assign w_mul_done = (r_state == S_MUL) && w_last && !em_i_flush;

    // NOTE: iteration registers carry no reset; they are always loaded on start before use.
    always_ff @(posedge em_i_clk) begin
        if (w_start_mul) begin
            r_mcand  <= {{DWIDTH{1'b0}}, w_rs_mag};
            r_mplier <= w_rt_mag;
            r_acc    <= '0;
            r_mneg   <= w_rs_neg ^ w_rt_neg;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

`ifdef EXECUTE_MC_DIV_EN
    logic [DWIDTH-1:0] r_quo, r_rem, r_dvsr, r_dvnd;
    logic              r_qneg, r_rneg, r_div_zero, w_ge;
    logic [DWIDTH:0]   w_shift;
    logic [DWIDTH-1:0] w_rem_next, w_quo_next;

    assign w_start_div = w_accept && ((w_op == OP_DIV) || (w_op == OP_DIVU));
    assign w_shift     = {r_rem, r_quo[DWIDTH-1]};
    assign w_ge        = (w_shift >= {1'b0, r_dvsr});
    assign w_rem_next  = w_ge ? (w_shift[DWIDTH-1:0] - r_dvsr) : w_shift[DWIDTH-1:0];
    assign w_quo_next  = {r_quo[DWIDTH-2:0], w_ge};
    assign w_div_done  = (r_state == S_DIV) && w_last && !em_i_flush;
    // A zero divisor bypasses sign correction so LO is all ones and HI the raw dividend.
    assign w_div_lo    = r_div_zero ? '1 : (r_qneg ? -w_quo_next : w_quo_next);
    assign w_div_hi    = r_div_zero ? r_dvnd : (r_rneg ? -w_rem_next : w_rem_next);

    always_ff @(posedge em_i_clk) begin
        if (w_start_div) begin
            r_quo      <= w_rs_mag;
            r_rem      <= '0;
            r_dvsr     <= w_rt_mag;
            r_dvnd     <= em_i_data_rs;
            r_qneg     <= w_rs_neg ^ w_rt_neg;
            r_rneg     <= w_rs_neg;
            r_div_zero <= (em_i_data_rt == '0);
        end else if (r_state == S_DIV) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
        end
    end
`else
    assign w_start_div = 1'b0;
    assign w_div_done  = 1'b0;
    assign w_div_lo    = '0;
    assign w_div_hi    = '0;
`endif

    always_ff @(posedge em_i_clk or posedge em_i_rst) begin
        if (em_i_rst) begin
            r_hi           <= '0;
            r_lo           <= '0;
            em_o_valid     <= 1'b0;
            em_o_alu_value <= '0;
            em_o_zero      <= 1'b0;
            em_o_change_pc <= 1'b0;
            em_o_alu_pc    <= '0;
        end else begin
            em_o_valid     <= 1'b0;
            em_o_change_pc <= 1'b0;
            if (w_accept && !w_start_mul && !w_start_div) begin
                em_o_valid     <= 1'b1;
                em_o_alu_value <= w_res;
                em_o_zero      <= (w_res == '0);
                em_o_change_pc <= w_taken;
                em_o_alu_pc    <= w_taken ? em_i_pc + w_br_off : '0;
            end else if (w_mul_done) begin
                r_hi           <= w_prod[2*DWIDTH-1:DWIDTH];
                r_lo           <= w_prod[DWIDTH-1:0];
                em_o_valid     <= 1'b1;
                em_o_alu_value <= w_prod[DWIDTH-1:0];
                em_o_zero      <= (w_prod[DWIDTH-1:0] == '0);
                em_o_alu_pc    <= '0;
            end else if (w_div_done) begin
                r_hi           <= w_div_hi;
                r_lo           <= w_div_lo;
                em_o_valid     <= 1'b1;
                em_o_alu_value <= w_div_lo;
                em_o_zero      <= (w_div_lo == '0);
                em_o_alu_pc    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
// tb_execute_mc: directed plus randomized stimulus for execute_mc, scored against a
// plain-arithmetic model of the ALU, branches and HI/LO; honours EXECUTE_MC_DIV_EN.
`timescale 1ns/1ps
module tb_execute_mc;
    localparam int DW = 32;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_alu_src, i_flush;
    logic [3:0]    i_op;
    logic [DW-1:0] i_rs, i_rt;
    logic [15:0]   i_imm;
    logic [PW-1:0] i_pc;
    logic          o_ready, o_valid, o_zero, o_change_pc;
    logic [DW-1:0] o_alu_value;
    logic [PW-1:0] o_alu_pc;

    typedef struct {
        string         name;
        logic [DW-1:0] value;
        logic          zero;
        logic          change;
        logic [PW-1:0] pc;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_hi, m_lo;
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    string op_name [16] = '{"add", "sub", "and", "or", "xor", "slt", "sltu", "mult",
                            "multu", "div", "divu", "mfhi", "mflo", "beq", "bne", "nop"};

    execute_mc #(.DWIDTH(DW), .PC_WIDTH(PW)) dut (
        .em_i_clk(clk),
        .em_i_rst(rst),
        .em_i_valid(i_valid),
        .em_o_ready(o_ready),
        .em_i_op(i_op),
        .em_i_data_rs(i_rs),
        .em_i_data_rt(i_rt),
        .em_i_imm(i_imm),
        .em_i_alu_src(i_alu_src),
        .em_i_pc(i_pc),
        .em_i_flush(i_flush),
        .em_o_valid(o_valid),
        .em_o_alu_value(o_alu_value),
        .em_o_zero(o_zero),
        .em_o_change_pc(o_change_pc),
        .em_o_alu_pc(o_alu_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: HI/LO change at acceptance; due is the extra cycles before valid.
    function automatic exp_t model(input logic [3:0] op, input logic [DW-1:0] rs,
                                   input logic [DW-1:0] rt, input logic [15:0] imm,
                                   input logic src, input logic [PW-1:0] pc);
        exp_t        e;
        logic [DW-1:0] immx, b;
        logic [63:0] p;
        immx     = {{(DW-16){imm[15]}}, imm};
        b        = (src && op <= 4'd6) ? immx : rt;
        e.name   = op_name[op];
        e.value  = '0;
        e.change = 1'b0;
        e.pc     = '0;
        e.due    = 0;
        case (op)
            4'd0: e.value = rs + b;
            4'd1: e.value = rs - b;
            4'd2: e.value = rs & b;
            4'd3: e.value = rs | b;
            4'd4: e.value = rs ^ b;
            4'd5: e.value = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: e.value = (rs < b) ? 32'd1 : 32'd0;
            4'd7: begin
                p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
                m_hi = p[63:32]; m_lo = p[31:0]; e.value = m_lo; e.due = DW;
            end
            4'd8: begin
                p = {32'd0, rs} * {32'd0, rt};
                m_hi = p[63:32]; m_lo = p[31:0]; e.value = m_lo; e.due = DW;
            end
`ifdef EXECUTE_MC_DIV_EN
            4'd9: begin
                if (rt == '0) begin m_lo = '1; m_hi = rs; end
                else begin
                    m_lo = $signed(rs) / $signed(rt);
                    m_hi = $signed(rs) % $signed(rt);
                end
                e.value = m_lo; e.due = DW;
            end
            4'd10: begin
                if (rt == '0) begin m_lo = '1; m_hi = rs; end
                else begin m_lo = rs / rt; m_hi = rs % rt; end
                e.value = m_lo; e.due = DW;
            end
`endif
            4'd11: e.value = m_hi;
            4'd12: e.value = m_lo;
            4'd13, 4'd14: begin
                e.value  = rs - rt;
                e.change = (op == 4'd13) ? (rs == rt) : (rs != rt);
                e.pc     = e.change ? pc + (immx << 2) : '0;
            end
            default: e.value = '0;
        endcase
        e.zero = (e.value == '0);
        return e;
    endfunction

    // Called between a falling and the next rising edge; returns at a falling edge.
    task automatic issue(input logic [3:0] op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                         input logic [15:0] imm, input logic src, input logic [PW-1:0] pc,
                         input bit expect_res, output int waits);
        exp_t e;
        i_op = op; i_rs = rs; i_rt = rt; i_imm = imm; i_alu_src = src; i_pc = pc;
        i_valid = 1'b1;
        waits = 0;
        while (!o_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!o_ready) begin
            check("ready_timeout", 64'(o_ready), 64'd1);
            i_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (expect_res) begin
            e = model(op, rs, rt, imm, src, pc);
            e.due = cyc + e.due;
            exp_q.push_back(e);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 64'd0);
        check({tag, "_value"}, 64'(o_alu_value), 64'd0);
        check({tag, "_zero"}, 64'(o_zero), 64'd0);
        check({tag, "_change_pc"}, 64'(o_change_pc), 64'd0);
        check({tag, "_alu_pc"}, 64'(o_alu_pc), 64'd0);
        check({tag, "_ready"}, 64'(o_ready), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 64'(o_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_value"}, 64'(o_alu_value), 64'(e.value));
                check({e.name, "_zero"}, 64'(o_zero), 64'(e.zero));
                check({e.name, "_change_pc"}, 64'(o_change_pc), 64'(e.change));
                check({e.name, "_alu_pc"}, 64'(o_alu_pc), 64'(e.pc));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_op = '0; i_rs = '0; i_rt = '0;
        i_imm = '0; i_alu_src = 1'b0; i_pc = '0;
        m_hi = '0; m_lo = '0;
        #1;
        check_outputs_clear("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 64'(o_ready), 64'd1);

        issue(4'd0, 32'd5, 32'hFFFF_FFFB, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd0, 32'd10, 32'd0, 16'hFFF6, 1'b1, 32'h0, 1'b1, w);
        issue(4'd13, 32'd7, 32'd7, 16'hFFFF, 1'b0, 32'h100, 1'b1, w);
        issue(4'd14, 32'd7, 32'd7, 16'hFFFF, 1'b0, 32'h100, 1'b1, w);
        issue(4'd5, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd6, 32'hFFFF_FFFF, 32'd1, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd15, 32'd9, 32'd9, 16'd9, 1'b0, 32'h0, 1'b1, w);

        issue(4'd7, 32'hFFFF_FFFD, 32'd4, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd11, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        check("mult_busy_cycles", 64'(w), 64'd32);
        issue(4'd12, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        check("mflo_no_wait", 64'(w), 64'd0);

`ifdef EXECUTE_MC_DIV_EN
        issue(4'd10, 32'd7, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd11, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        check("div_busy_cycles", 64'(w), 64'd32);
        issue(4'd9, 32'hFFFF_FFF9, 32'd2, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd11, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
`endif

        issue(4'd7, 32'h1234_5678, 32'h9ABC_DEF0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd8, 32'hDEAD_BEEF, 32'h0000_1234, 16'd0, 1'b0, 32'h0, 1'b0, w);
        repeat (9) @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("ready_after_flush", 64'(o_ready), 64'd1);
        issue(4'd11, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd12, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);

`ifdef EXECUTE_MC_DIV_EN
        issue(4'd9, 32'd100, 32'd7, 16'd0, 1'b0, 32'h0, 1'b0, w);
`else
        issue(4'd7, 32'd100, 32'd7, 16'd0, 1'b0, 32'h0, 1'b0, w);
`endif
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_clear("midop_reset");
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        check("ready_after_midop_reset", 64'(o_ready), 64'd1);
        issue(4'd0, 32'd3, 32'd4, 16'd0, 1'b0, 32'h0, 1'b1, w);
        check("add_after_reset_wait", 64'(w), 64'd0);
        issue(4'd11, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);
        issue(4'd12, 32'd0, 32'd0, 16'd0, 1'b0, 32'h0, 1'b1, w);

        for (int k = 0; k < 150; k++) begin
            logic [3:0]    op;
            logic [DW-1:0] rs, rt;
            op = 4'($urandom_range(0, 15));
            rs = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
            case ($urandom_range(0, 7))
                0, 1:    rt = rs;
                2:       rt = '0;
                3:       rt = DW'($urandom_range(0, 9));
                default: rt = DW'($urandom);
            endcase
            if (op == 4'd9 && rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) rt = 32'd1;
            issue(op, rs, rt, 16'($urandom), 1'($urandom), DW'($urandom) & 32'hFFFF_FFFC, 1'b1, w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (DW + 4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameter DWIDTH, default 32: operand/result width; legal values 8..64, even.
REQ-002 Parameter PC_WIDTH, default 32: program-counter width.
REQ-003 em_i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 em_i_rst  input  1  asynchronous, active-high reset.
REQ-005 em_i_valid  input  1  operation presented this cycle.
REQ-006 em_o_ready  output  1  block accepts an operation this cycle.
REQ-007 em_i_op  input  4  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 MULT, 8 MULTU, 9 DIV, 10 DIVU, 11 MFHI, 12 MFLO, 13 BEQ, 14 BNE, 15 NOP.
REQ-008 em_i_data_rs, em_i_data_rt  input  DWIDTH  source operands.
REQ-009 em_i_imm  input  16  immediate, sign-extended to DWIDTH.
REQ-010 em_i_alu_src  input  1  1 selects the immediate as second operand for ops 0-6.
REQ-011 em_i_pc  input  PC_WIDTH  PC+4 of the operation.
REQ-012 em_i_flush  input  1  discard the accepted or in-flight operation.
REQ-013 em_o_valid  output  1  result registers hold a completed operation.
REQ-014 em_o_alu_value  output  DWIDTH  registered result.
REQ-015 em_o_zero  output  1  registered flag: em_o_alu_value equals zero.
REQ-016 em_o_change_pc, em_o_alu_pc  output  1, PC_WIDTH  registered branch-taken flag and target.

Function
REQ-017 Handshake: an operation is accepted when em_i_valid and em_o_ready are both high on a rising edge.
REQ-018 Ops 0-6 and 11-15 SHALL complete with 1-cycle latency: em_o_valid is high exactly one cycle after acceptance, for one cycle.
REQ-019 SLT SHALL compare signed operands and SLTU unsigned; the result is 1 or 0, zero-extended.
REQ-020 BEQ/BNE SHALL compute rs-rt; taken when the difference is zero (BEQ) or nonzero (BNE); target = em_i_pc + (sign-extended imm << 2), truncated to PC_WIDTH; when not taken, em_o_change_pc=0 and em_o_alu_pc=0.
REQ-021 MULT/MULTU SHALL use a shift-add iterative unit of exactly DWIDTH cycles, writing the 2*DWIDTH product to HI (upper) and LO (lower); em_o_valid pulses once on completion with em_o_alu_value=LO.
REQ-022 FSM states: IDLE, MUL, DIV, DONE; IDLE->MUL/DIV on acceptance of ops 7-10; MUL/DIV->DONE when the iteration counter reaches DWIDTH-1; DONE->IDLE on the next cycle.
REQ-023 em_o_ready SHALL be high only in IDLE and DONE; during MUL/DIV em_o_ready=0.
REQ-024 Signed ops SHALL operate on magnitudes, then negate: product sign = sign rs XOR sign rt; quotient likewise; remainder takes the sign of the dividend.
REQ-025 DIV/DIVU SHALL produce quotient in LO and remainder in HI; a zero divisor SHALL yield LO=all ones and HI=dividend, with no exception, in the same cycle count.
REQ-026 MFHI/MFLO SHALL return HI/LO; an MFHI/MFLO accepted in DONE SHALL observe the just-written values.
REQ-027 em_i_flush SHALL take priority over acceptance: it aborts MUL/DIV and returns the FSM to IDLE, leaves HI/LO unchanged, and clears em_o_valid and em_o_change_pc on the next edge.
REQ-028 NOP SHALL assert em_o_valid with em_o_alu_value=0 and em_o_zero=1.

Reset
REQ-029 Reset SHALL force IDLE and clear the counter, HI, LO, em_o_valid, em_o_alu_value, em_o_change_pc and em_o_alu_pc to 0, and set em_o_zero to 0.
REQ-030 em_o_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.
REQ-031 Reset asserted mid-MUL/DIV SHALL abandon the operation with no em_o_valid pulse.

Configuration
REQ-032 Macro EXECUTE_MC_DIV_EN: when defined, the divider, DIV/DIVU and the DIV state are built per REQ-022 and REQ-024 to REQ-025.
REQ-033 When EXECUTE_MC_DIV_EN is undefined, DIV/DIVU SHALL behave as NOP per REQ-028 with 1-cycle latency, and HI/LO SHALL remain unchanged.

Verification
REQ-034 ADD rs=5, rt=0xFFFFFFFB -> one cycle later em_o_valid=1, em_o_alu_value=0, em_o_zero=1.
REQ-035 BEQ rs=rt=7, pc=0x100, imm=0xFFFF -> em_o_change_pc=1, em_o_alu_pc=0xFC; BNE with the same inputs -> em_o_change_pc=0, em_o_alu_pc=0.
REQ-036 MULT rs=-3, rt=4, then MFHI -> em_o_ready=0 for 32 cycles; LO=0xFFFFFFF4; MFHI returns 0xFFFFFFFF.
REQ-037 DIVU rs=7, rt=0 (EXECUTE_MC_DIV_EN defined) -> LO=0xFFFFFFFF, HI=7; DIV rs=-7, rt=2 -> LO=-3, HI=-1.
REQ-038 Flush at iteration 10 of MULTU -> no em_o_valid pulse, em_o_ready=1 on the next cycle, HI/LO keep their prior values.
REQ-039 Reset pulse during DIV -> all outputs 0, FSM in IDLE, ADD accepted in the first cycle after release.
